// File: rtl/ones_counter_pipe.sv
// -----------------------------------------------------------------------------
// ones_counter_pipe
//
// Purpose:
//   Counts the set bits of each valid input word and presents the result with
//   a latency of PIPE_STAGES cycles (1 or 2). It can also add each count into
//   a running accumulator that has a sticky overflow flag and a threshold
//   compare. The mode and clear inputs travel through the pipeline with their
//   word. A clear with no valid word still travels as a clear-only token.
//
// Build option:
//   ONES_CNT_SAT_EN  When defined, the accumulator saturates at 2^ACC_W-1
//                    instead of wrapping. acc_ovf_o sets on the first add
//                    that would exceed the maximum.
//
// Parameters:
//   DATA_W       input word width (2..64)
//   ACC_W        accumulator width (>= CNT_W)
//   PIPE_STAGES  popcount latency, 1 or 2
//   CNT_W        derived count width, $clog2(DATA_W+1)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   data_i         word to count
//   in_valid_i     data qualifier
//   mode_i         0 = per-word count only, 1 = also accumulate
//   clear_i        zero the accumulator and the overflow flag
//   thresh_i       threshold for thresh_hit_o
//   count_o        popcount of the word leaving the pipeline (held when idle)
//   count_valid_o  one pulse per accepted word
//   acc_o          running accumulated total
//   acc_ovf_o      sticky accumulator overflow
//   thresh_hit_o   acc_o >= thresh_i (combinational from registered acc)
// -----------------------------------------------------------------------------
module ones_counter_pipe #(
   parameter  int DATA_W      = 8,
   parameter  int ACC_W       = 16,
   parameter  int PIPE_STAGES = 1,
   localparam int CNT_W       = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              in_valid_i,
   input  logic              mode_i,
   input  logic              clear_i,
   input  logic [ACC_W-1:0]  thresh_i,
   output logic [CNT_W-1:0]  count_o,
   output logic              count_valid_o,
   output logic [ACC_W-1:0]  acc_o,
   output logic              acc_ovf_o,
   output logic              thresh_hit_o
);

   // Lower half gets the extra bit when DATA_W is odd.
   localparam int HI_W = DATA_W / 2;
   localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> HI_W;

   // Illegal configurations are rejected when the design is elaborated.
   generate
      if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
         $error("ones_counter_pipe: PIPE_STAGES must be 1 or 2");
      end
      if (DATA_W < 2 || DATA_W > 64) begin : g_bad_data_w
         $error("ones_counter_pipe: DATA_W must be in 2..64");
      end
      if (ACC_W < CNT_W) begin : g_bad_acc_w
         $error("ones_counter_pipe: ACC_W must be >= CNT_W");
      end
   endgenerate

   function automatic logic [CNT_W-1:0] popcnt(input logic [DATA_W-1:0] w);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_W; i++) begin
         c = c + CNT_W'(w[i]);
      end
      return c;
   endfunction

   // Token that reaches the output stage on the next rising edge.
   logic             tok_valid;
   logic             tok_mode;
   logic             tok_clear;
   logic [CNT_W-1:0] tok_cnt;

   generate
      if (PIPE_STAGES == 2) begin : g_pipe2
         logic [CNT_W-1:0] lo_cnt_q;
         logic [CNT_W-1:0] hi_cnt_q;
         logic             s1_valid_q;
         logic             s1_mode_q;
         logic             s1_clear_q;

         // The stage-1 valid bit is always written, so a reset drops any
         // word that is in flight. The half counts only need updating when
         // a word is present.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               lo_cnt_q   <= '0;
               hi_cnt_q   <= '0;
               s1_valid_q <= 1'b0;
               s1_mode_q  <= 1'b0;
               s1_clear_q <= 1'b0;
            end else begin
               s1_valid_q <= in_valid_i;
               s1_mode_q  <= mode_i;
               s1_clear_q <= clear_i;
               if (in_valid_i) begin
                  lo_cnt_q <= popcnt(data_i & LO_MASK);
                  hi_cnt_q <= popcnt(data_i & ~LO_MASK);
               end
            end
         end

         // Both halves together never exceed DATA_W, so CNT_W bits hold the sum.
         assign tok_valid = s1_valid_q;
         assign tok_mode  = s1_mode_q;
         assign tok_clear = s1_clear_q;
         assign tok_cnt   = lo_cnt_q + hi_cnt_q;
      end else begin : g_pipe1
         assign tok_valid = in_valid_i;
         assign tok_mode  = mode_i;
         assign tok_clear = clear_i;
         assign tok_cnt   = popcnt(data_i);
      end
   endgenerate

   // Output stage.
   logic [CNT_W-1:0] count_q,       count_d;
   logic             count_valid_q, count_valid_d;
   logic [ACC_W-1:0] acc_q,         acc_d;
   logic             acc_ovf_q,     acc_ovf_d;

   logic [ACC_W-1:0] cnt_ext;
   logic [ACC_W:0]   acc_sum;

   assign cnt_ext = ACC_W'(tok_cnt);
   // The extra top bit of the sum is the carry out of the accumulator.
   assign acc_sum = {1'b0, acc_q} + {1'b0, cnt_ext};

   always_comb begin
      count_d       = count_q;
      count_valid_d = tok_valid;
      acc_d         = acc_q;
      acc_ovf_d     = acc_ovf_q;

      if (tok_valid) begin
         count_d = tok_cnt;
      end

      if (tok_clear) begin
         // Clear-then-add: the word carrying the clear still counts.
         // Because ACC_W >= CNT_W, this add cannot overflow.
         acc_ovf_d = 1'b0;
         if (tok_valid && tok_mode) begin
            acc_d = cnt_ext;
         end else begin
            acc_d = '0;
         end
      end else if (tok_valid && tok_mode) begin
`ifdef ONES_CNT_SAT_EN
         if (acc_sum[ACC_W]) begin
            acc_d     = '1;
            acc_ovf_d = 1'b1;
         end else begin
            acc_d = acc_sum[ACC_W-1:0];
         end
`else
         acc_d = acc_sum[ACC_W-1:0];
         if (acc_sum[ACC_W]) begin
            acc_ovf_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q       <= '0;
         count_valid_q <= 1'b0;
         acc_q         <= '0;
         acc_ovf_q     <= 1'b0;
      end else begin
         count_q       <= count_d;
         count_valid_q <= count_valid_d;
         acc_q         <= acc_d;
         acc_ovf_q     <= acc_ovf_d;
      end
   end

   assign count_o       = count_q;
   assign count_valid_o = count_valid_q;
   assign acc_o         = acc_q;
   assign acc_ovf_o     = acc_ovf_q;
   assign thresh_hit_o  = (acc_q >= thresh_i);

endmodule
